arrow_key_ctrl: RTL and testbench
=================================

ARROW_KEY_CTRL -- requirements
Module: arrow_key_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 1000, idle cycles before an incomplete prefix sequence is abandoned (used only with ARROW_TIMEOUT_EN).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: byte_in  input  8  received PS/2 scan byte.
REQ-005 SHALL have port: byte_valid  input  1  byte_in qualifier; one byte accepted per cycle when high.
REQ-006 SHALL have port: scancode  output  16  last completed code, {8'hE0,byte} when extended, {8'h00,byte} otherwise.
REQ-007 SHALL have port: code_valid  output  1  one-cycle pulse when scancode updates.
REQ-008 SHALL have port: make  output  1  qualifies scancode: 1 = press, 0 = release.
REQ-009 SHALL have ports: left, down, right, up  output  1 each  held arrow-key state, 1 while pressed.

Function
REQ-010 SHALL implement FSM states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen); only bytes with byte_valid=1 cause transitions.
REQ-011 IDLE: E0 -> EXT; F0 -> BRK; any other byte -> emit {00,byte}, make=1, stay IDLE.
REQ-012 EXT: F0 -> EXT_BRK; E0 -> stay EXT, no emit; other -> emit {E0,byte}, make=1, -> IDLE.
REQ-013 BRK: E0 or F0 -> no emit, stay BRK; other -> emit {00,byte}, make=0, -> IDLE.
REQ-014 EXT_BRK: E0 or F0 -> no emit, stay EXT_BRK; other -> emit {E0,byte}, make=0, -> IDLE.
REQ-015 Bytes 00 and FF (keyboard error/overrun) SHALL, in any state, force IDLE with no emit and no held-flag change.
REQ-016 Emit SHALL register scancode and make and pulse code_valid for exactly one cycle, on the clock edge that accepts the final byte (output visible the cycle after byte_valid).
REQ-017 scancode and make SHALL hold their values between emits.
REQ-018 Arrow flags SHALL update on the emit edge: E06B->left, E072->down, E074->right, E075->up; make=1 sets, make=0 clears.
REQ-019 Non-arrow codes, including non-extended 6B/72/74/75, SHALL NOT change any arrow flag.
REQ-020 Repeated make (typematic) SHALL re-emit with code_valid each time; the flag stays 1.
REQ-021 Multiple arrow flags MAY be 1 simultaneously; each is independent.
REQ-022 Back-to-back bytes on consecutive cycles SHALL be accepted with no lost bytes.

Reset
REQ-023 rst high SHALL immediately force state IDLE, scancode=16'h0000, code_valid=0, make=0, left=down=right=up=0, timeout counter=0.
REQ-024 Reset mid-sequence (EXT/BRK/EXT_BRK) SHALL discard the partial sequence; the first byte after release is treated from IDLE.

Configuration
REQ-025 Macro ARROW_TIMEOUT_EN defined: in any non-IDLE state, a counter SHALL count cycles with byte_valid=0, clear on each accepted byte, and return FSM to IDLE with no emit when count reaches TIMEOUT_CYCLES; counter held at 0 in IDLE.
REQ-026 Macro ARROW_TIMEOUT_EN undefined: no counter SHALL be built; non-IDLE states wait indefinitely for the next byte.

Verification
REQ-027 Bytes E0,6B -> code_valid pulse, scancode=E06B, make=1, left=1; then E0,F0,6B -> scancode=E06B, make=0, left=0.
REQ-028 E0,75 then E0,6B -> up=1 and left=1 together; E0,F0,75 -> up=0, left stays 1.
REQ-029 Byte 1C -> scancode=001C, make=1, no arrow change; F0,1C -> scancode=001C, make=0; 6B alone -> scancode=006B, left unchanged.
REQ-030 E0 then rst pulse then 72 -> scancode=0072, make=1, down=0; E0,FF,74 -> scancode=0074, right=0.
REQ-031 With ARROW_TIMEOUT_EN, TIMEOUT_CYCLES=8: E0, 8 idle cycles, then 74 -> scancode=0074, right=0; E0, 7 idle cycles, 74 -> scancode=E074, right=1.
REQ-032 E0,72,E0,72 on four consecutive cycles -> two code_valid pulses, both E072, make=1, down=1.

Source files
------------

// File: rtl/arrow_key_ctrl.sv
// PS/2 scan-byte decoder: assembles E0/F0 prefix sequences into scancodes and tracks arrow-key hold state.
// Optional build macro ARROW_TIMEOUT_EN abandons an incomplete prefix after TIMEOUT_CYCLES idle cycles.
module arrow_key_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [15:0] scancode,
    output logic        code_valid,
    output logic        make,
    output logic        left,
    output logic        down,
    output logic        right,
    output logic        up
);

    // state   | meaning
    // IDLE    | no prefix pending
    // EXT     | E0 seen
    // BRK     | F0 seen
    // EXT_BRK | E0 F0 seen
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] EXT     = 2'd1;
    localparam logic [1:0] BRK     = 2'd2;
    localparam logic [1:0] EXT_BRK = 2'd3;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("arrow_key_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        emit;
    logic [15:0] emit_code;
    logic        emit_make;
    logic        is_e0;
    logic        is_f0;
    logic        err_byte;
    logic        timeout_hit;

    assign is_e0    = (byte_in == 8'hE0);
    assign is_f0    = (byte_in == 8'hF0);
    assign err_byte = (byte_in == 8'h00) || (byte_in == 8'hFF);

`ifdef ARROW_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] idle_cnt;

    // Fires on the idle cycle that brings the count to TIMEOUT_CYCLES.
    assign timeout_hit = (state != IDLE) && !byte_valid && (idle_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if ((state == IDLE) || byte_valid || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        emit_code = {8'h00, byte_in};
        emit_make = 1'b1;
        if (byte_valid) begin
            if (err_byte) begin
                state_nxt = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (is_e0)      state_nxt = EXT;
                        else if (is_f0) state_nxt = BRK;
                        else            emit = 1'b1;
                    end
                    EXT: begin
                        if (is_f0) begin
                            state_nxt = EXT_BRK;
                        end else if (!is_e0) begin
                            emit      = 1'b1;
                            emit_code = {8'hE0, byte_in};
                            state_nxt = IDLE;
                        end
                    end
                    BRK: begin
                        if (!is_e0 && !is_f0) begin
                            emit      = 1'b1;
                            emit_make = 1'b0;
                            state_nxt = IDLE;
                        end
                    end
                    EXT_BRK: begin
                        if (!is_e0 && !is_f0) begin
                            emit      = 1'b1;
                            emit_code = {8'hE0, byte_in};
                            emit_make = 1'b0;
                            state_nxt = IDLE;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end else if (timeout_hit) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            scancode   <= 16'h0000;
            code_valid <= 1'b0;
            make       <= 1'b0;
            left       <= 1'b0;
            down       <= 1'b0;
            right      <= 1'b0;
            up         <= 1'b0;
        end else begin
            state      <= state_nxt;
            code_valid <= emit;
            if (emit) begin
                scancode <= emit_code;
                make     <= emit_make;
                // Only extended codes map to arrows; plain 6B/72/74/75 are keypad keys.
                if (emit_code[15:8] == 8'hE0) begin
                    case (emit_code[7:0])
                        8'h6B:   left  <= emit_make;
                        8'h72:   down  <= emit_make;
                        8'h74:   right <= emit_make;
                        8'h75:   up    <= emit_make;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_arrow_key_ctrl.sv
// Scoreboard bench for arrow_key_ctrl: directed byte sequences queue expected emits; a monitor checks each code_valid pulse.
module tb_arrow_key_ctrl;

    typedef struct packed {
        logic [15:0] sc;
        logic        mk;
        logic [3:0]  fl;   // {left, down, right, up}
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic [15:0] scancode;
    logic        code_valid;
    logic        make;
    logic        left, down, right, up;

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];

    arrow_key_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .scancode   (scancode),
        .code_valid (code_valid),
        .make       (make),
        .left       (left),
        .down       (down),
        .right      (right),
        .up         (up)
    );

    always #5 clk = ~clk;

    // Monitor: every code_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && code_valid) begin
            exp_t act;
            exp_t exp;
            act = '{sc: scancode, mk: make, fl: {left, down, right, up}};
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_emit actual sc=%h mk=%b fl=%b required none", act.sc, act.mk, act.fl);
            end else begin
                exp = sb_q.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL emit actual sc=%h mk=%b fl=%b required sc=%h mk=%b fl=%b",
                             act.sc, act.mk, act.fl, exp.sc, exp.mk, exp.fl);
                end
            end
        end
    end

    task automatic expect_code(input logic [15:0] sc, input logic mk, input logic [3:0] fl);
        sb_q.push_back('{sc: sc, mk: mk, fl: fl});
    endtask

    task automatic send(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check_val({name, "_sc"}, {16'h0, scancode}, 32'h0);
        check_val({name, "_ctl"}, {26'h0, code_valid, make, left, down, right, up}, 32'h0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(1);

        // Extended left press / release
        expect_code(16'hE06B, 1'b1, 4'b1000);
        send(8'hE0); send(8'h6B);
        expect_code(16'hE06B, 1'b0, 4'b0000);
        send(8'hE0); send(8'hF0); send(8'h6B);

        // Simultaneous up + left, then release up only
        expect_code(16'hE075, 1'b1, 4'b0001);
        send(8'hE0); send(8'h75);
        expect_code(16'hE06B, 1'b1, 4'b1001);
        send(8'hE0); send(8'h6B);
        expect_code(16'hE075, 1'b0, 4'b1000);
        send(8'hE0); send(8'hF0); send(8'h75);

        // Non-arrow and non-extended 6B leave flags alone
        expect_code(16'h001C, 1'b1, 4'b1000);
        send(8'h1C);
        expect_code(16'h001C, 1'b0, 4'b1000);
        send(8'hF0); send(8'h1C);
        expect_code(16'h006B, 1'b1, 4'b1000);
        send(8'h6B);

        // Outputs hold between emits
        idle(5);
        check_val("hold_sc", {16'h0, scancode}, 32'h0000_006B);
        check_val("hold_mk_cv", {30'h0, make, code_valid}, 32'h2);

        // Typematic repeat, then release left
        expect_code(16'hE06B, 1'b1, 4'b1000);
        send(8'hE0); send(8'h6B);
        expect_code(16'hE06B, 1'b0, 4'b0000);
        send(8'hE0); send(8'hF0); send(8'h6B);

        // Reset mid-sequence discards the pending E0
        send(8'hE0);
        #3 rst = 1'b1;
        #2 check_reset_outputs("midreset");
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        expect_code(16'h0072, 1'b1, 4'b0000);
        send(8'h72);

        // FF aborts an extended prefix
        expect_code(16'h0074, 1'b1, 4'b0000);
        send(8'hE0); send(8'hFF); send(8'h74);

        // Repeated prefixes inside BRK, and 00 aborting BRK
        expect_code(16'h001C, 1'b0, 4'b0000);
        send(8'hF0); send(8'hE0); send(8'hF0); send(8'h1C);
        expect_code(16'h001C, 1'b1, 4'b0000);
        send(8'hF0); send(8'h00); send(8'h1C);

        // Back-to-back bytes, two emits
        expect_code(16'hE072, 1'b1, 4'b0100);
        expect_code(16'hE072, 1'b1, 4'b0100);
        send(8'hE0); send(8'h72); send(8'hE0); send(8'h72);
        expect_code(16'hE072, 1'b0, 4'b0000);
        send(8'hE0); send(8'hF0); send(8'h72);

        // Extended non-arrow with repeated E0
        expect_code(16'hE01F, 1'b1, 4'b0000);
        send(8'hE0); send(8'hE0); send(8'h1F);

`ifdef ARROW_TIMEOUT_EN
        expect_code(16'h0074, 1'b1, 4'b0000);
        send(8'hE0); idle(8); send(8'h74);
        expect_code(16'hE074, 1'b1, 4'b0010);
        send(8'hE0); idle(7); send(8'h74);
`else
        expect_code(16'hE074, 1'b1, 4'b0010);
        send(8'hE0); idle(20); send(8'h74);
`endif
        expect_code(16'hE074, 1'b0, 4'b0000);
        send(8'hE0); send(8'hF0); send(8'h74);

        idle(4);
        check_val("queue_drained", sb_q.size(), 32'd0);
        check_val("final_flags", {28'h0, left, down, right, up}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
